// File: rtl/sprite_pixel_streamer.sv
// Snapshots one sprite from the flattened asset buses and emits it as a raster-ordered
// valid/ready pixel stream. Optional macro SPRITE_SKIP_TRANSPARENT_EN suppresses transparent beats.
module sprite_pixel_streamer #(
  parameter int TILE_SIZE = 16,
  parameter int IDX_W     = $clog2(TILE_SIZE*TILE_SIZE)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              abort,
  input  logic                              mode,
  input  logic [11:0]                       fg_color,
  input  logic [TILE_SIZE*TILE_SIZE-1:0]    mask_in,
  input  logic [4*TILE_SIZE*TILE_SIZE-1:0]  r_in,
  input  logic [4*TILE_SIZE*TILE_SIZE-1:0]  g_in,
  input  logic [4*TILE_SIZE*TILE_SIZE-1:0]  b_in,
  output logic                              busy,
  output logic                              pix_valid,
  input  logic                              pix_ready,
  output logic [$clog2(TILE_SIZE)-1:0]      pix_x,
  output logic [$clog2(TILE_SIZE)-1:0]      pix_y,
  output logic [11:0]                       pix_rgb,
  output logic                              pix_opaque,
  output logic                              pix_last,
  output logic                              done,
  output logic [1:0]                        state_dbg
);

  localparam int N  = TILE_SIZE*TILE_SIZE;
  localparam int XW = $clog2(TILE_SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N-1);

  // Handshake: a beat transfers on any rising edge where pix_valid && pix_ready;
  // beat fields are registered and stay frozen while pix_valid && !pix_ready.
  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, DONE = 2'd2} state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic               sh_mode;
  logic [11:0]        sh_fg;
  logic [N-1:0]       sh_mask;
  logic [4*N-1:0]     sh_r;
  logic [4*N-1:0]     sh_g;
  logic [4*N-1:0]     sh_b;

  logic               capture;
  logic               advance;
  logic               finish;
  logic               src_mode;
  logic [11:0]        src_fg;
  logic [N-1:0]       src_mask;
  logic [4*N-1:0]     src_r;
  logic [4*N-1:0]     src_g;
  logic [4*N-1:0]     src_b;
  logic [IDX_W-1:0]   nxt_idx;
  logic [IDX_W+1:0]   nib_base;
  logic               nb_opaque;
  logic               nb_last;
  logic               nb_valid;
  logic [11:0]        nb_rgb;
  logic [XW-1:0]      nb_x;
  logic [XW-1:0]      nb_y;

  assign state_dbg = state;
  assign capture   = (state == IDLE) && start && !abort;

`ifdef SPRITE_SKIP_TRANSPARENT_EN
  logic [IDX_W-1:0] enc_last;
  logic [IDX_W-1:0] sh_last;
  logic [IDX_W-1:0] src_last;

  // Highest set mask bit; an all-zero mask leaves pix_last unreachable.
  always_comb begin
    enc_last = '0;
    for (int i = 0; i < N; i++) begin
      if (mask_in[i]) enc_last = IDX_W'(i);
    end
  end

  assign src_last = capture ? enc_last : sh_last;
  assign nb_last  = nb_opaque && (nxt_idx == src_last);
  assign nb_valid = nb_opaque;
  assign advance  = !pix_valid || pix_ready;
  assign finish   = (pix_valid && pix_last) || (idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       sh_last <= '0;
    else if (capture) sh_last <= enc_last;
  end
`else
  assign nb_last  = (nxt_idx == LAST_IDX);
  assign nb_valid = 1'b1;
  assign advance  = pix_valid && pix_ready;
  assign finish   = pix_last;
`endif

  // The first beat is built straight from the input buses on the capture edge.
  always_comb begin
    src_mode  = capture ? mode     : sh_mode;
    src_fg    = capture ? fg_color : sh_fg;
    src_mask  = capture ? mask_in  : sh_mask;
    src_r     = capture ? r_in     : sh_r;
    src_g     = capture ? g_in     : sh_g;
    src_b     = capture ? b_in     : sh_b;
    nxt_idx   = capture ? '0 : idx + IDX_W'(1);
    nib_base  = {nxt_idx, 2'b00};
    nb_opaque = src_mask[nxt_idx];
    nb_x      = XW'(nxt_idx % TILE_SIZE);
    nb_y      = XW'(nxt_idx / TILE_SIZE);
    if (src_mode) nb_rgb = {src_r[nib_base +: 4], src_g[nib_base +: 4], src_b[nib_base +: 4]};
    else          nb_rgb = nb_opaque ? src_fg : 12'h000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      busy       <= 1'b0;
      pix_valid  <= 1'b0;
      pix_last   <= 1'b0;
      pix_opaque <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_rgb    <= '0;
      done       <= 1'b0;
      sh_mode    <= 1'b0;
      sh_fg      <= '0;
      sh_mask    <= '0;
      sh_r       <= '0;
      sh_g       <= '0;
      sh_b       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (capture) begin
            sh_mode    <= mode;
            sh_fg      <= fg_color;
            sh_mask    <= mask_in;
            sh_r       <= r_in;
            sh_g       <= g_in;
            sh_b       <= b_in;
            idx        <= '0;
            busy       <= 1'b1;
            state      <= STREAM;
            pix_valid  <= nb_valid;
            pix_last   <= nb_last;
            pix_opaque <= nb_opaque;
            pix_x      <= nb_x;
            pix_y      <= nb_y;
            pix_rgb    <= nb_rgb;
          end
        end
        STREAM: begin
          if (abort) begin
            state     <= IDLE;
            busy      <= 1'b0;
            pix_valid <= 1'b0;
            pix_last  <= 1'b0;
          end else if (advance) begin
            if (finish) begin
              state     <= DONE;
              pix_valid <= 1'b0;
              pix_last  <= 1'b0;
              done      <= 1'b1;
            end else begin
              idx        <= nxt_idx;
              pix_valid  <= nb_valid;
              pix_last   <= nb_last;
              pix_opaque <= nb_opaque;
              pix_x      <= nb_x;
              pix_y      <= nb_y;
              pix_rgb    <= nb_rgb;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          pix_valid <= 1'b0;
          pix_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_pixel_streamer.sv
// Scoreboard bench for sprite_pixel_streamer: a per-pixel reference model fills exp_q at
// start time; a negedge monitor pops and compares every accepted beat.
module tb_sprite_pixel_streamer;

  localparam int TS = 16;
  localparam int N  = TS*TS;
  localparam int XW = $clog2(TS);
  localparam int BW = 2*XW + 14;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic           mode = 1'b0;
  logic [11:0]    fg_color = '0;
  logic [N-1:0]   mask_in = '0;
  logic [4*N-1:0] r_in = '0;
  logic [4*N-1:0] g_in = '0;
  logic [4*N-1:0] b_in = '0;
  logic           pix_ready = 1'b1;
  logic           busy, pix_valid, pix_opaque, pix_last, done;
  logic [XW-1:0]  pix_x, pix_y;
  logic [11:0]    pix_rgb;
  logic [1:0]     state_dbg;

  sprite_pixel_streamer #(.TILE_SIZE(TS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .fg_color(fg_color), .mask_in(mask_in), .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .busy(busy), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x),
    .pix_y(pix_y), .pix_rgb(pix_rgb), .pix_opaque(pix_opaque), .pix_last(pix_last),
    .done(done), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int             n_tests = 0;
  int             n_fail  = 0;
  logic [BW-1:0]  exp_q[$];
  int             hs_count = 0;
  bit             done_due = 0, idle_due = 0, held = 0, force_done = 0, rdy_rand = 0;
  logic [BW-1:0]  held_beat;
  logic [BW-1:0]  cur_beat;

  assign cur_beat = {pix_x, pix_y, pix_rgb, pix_opaque, pix_last};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Reference model: walk every pixel of the sprite in raster order.
  task automatic push_sprite();
    int            last_op;
    logic          op;
    logic [11:0]   rgb;
    logic [XW-1:0] x, y;
    last_op = -1;
    for (int k = 0; k < N; k++) if (mask_in[k]) last_op = k;
    for (int k = 0; k < N; k++) begin
      op  = mask_in[k];
      rgb = mode ? {r_in[4*k +: 4], g_in[4*k +: 4], b_in[4*k +: 4]} : (op ? fg_color : 12'h000);
      x   = XW'(k % TS);
      y   = XW'(k / TS);
`ifdef SPRITE_SKIP_TRANSPARENT_EN
      if (op) exp_q.push_back({x, y, rgb, op, (k == last_op)});
`else
      exp_q.push_back({x, y, rgb, op, (k == N-1)});
`endif
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (done || done_due || force_done) check("done_pulse", 32'(done), 32'(done_due || force_done));
      if (done_due || force_done) begin
        check("busy_in_done", 32'(busy), 32'd1);
        check("valid_after_last", 32'(pix_valid), 32'd0);
      end
      if (idle_due) check("busy_after_done", 32'(busy), 32'd0);
      idle_due = done_due || force_done;
      done_due = 0;
      if (held && pix_valid) check("stall_hold", 32'(cur_beat), 32'(held_beat));
      held      = pix_valid && !pix_ready && !abort;
      held_beat = cur_beat;
      if (pix_valid && pix_ready && !abort) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got %0h required no beat", cur_beat);
        end else begin
          check("beat", 32'(cur_beat), 32'(exp_q.pop_front()));
        end
        hs_count++;
        if (pix_last) done_due = 1;
      end
    end else begin
      done_due = 0;
      idle_due = 0;
      held     = 0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rdy_rand) pix_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- driver tasks ----------------
  task automatic randomize_inputs();
    mode     = 1'($urandom_range(0, 1));
    fg_color = 12'($urandom);
    for (int k = 0; k < N; k++) begin
      mask_in[k]     = 1'($urandom_range(0, 1));
      r_in[4*k +: 4] = 4'($urandom);
      g_in[4*k +: 4] = 4'($urandom);
      b_in[4*k +: 4] = 4'($urandom);
    end
  endtask

  task automatic start_sprite();
    logic m0;
    @(posedge clk); #1;
    start = 1'b1;
    m0 = mask_in[0];
    push_sprite();
    @(posedge clk); #1;
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
`ifdef SPRITE_SKIP_TRANSPARENT_EN
    check("first_valid", 32'(pix_valid), 32'(m0));
`else
    check("first_valid", 32'(pix_valid), 32'(1'b1 | m0));
`endif
    randomize_inputs();
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (!busy && exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    check("stream_complete", 32'(ok), 32'd1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(pix_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_last", 32'(pix_last), 32'd0);
    check("rst_opaque", 32'(pix_opaque), 32'd0);
    check("rst_xy", 32'({pix_x, pix_y}), 32'd0);
    check("rst_rgb", 32'(pix_rgb), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    rst_n = 1'b1;

    // Mask mode, checkerboard, full-rate sink, plus an ignored start mid-stream.
    mode = 1'b0;
    fg_color = 12'hFF0;
    for (int k = 0; k < N; k++) mask_in[k] = (((k % TS) + (k / TS)) % 2) == 0;
    start_sprite();
    repeat (50) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_idle();

    // RGB mode, ramp red plane, full mask; inputs scrambled after capture.
    mode = 1'b1;
    mask_in = '1;
    for (int k = 0; k < N; k++) begin
      r_in[4*k +: 4] = 4'(k);
      g_in[4*k +: 4] = 4'h4;
      b_in[4*k +: 4] = 4'h0;
    end
    start_sprite();
    wait_idle();

    // Random back-pressure with random sprites.
    rdy_rand = 1;
    for (int s = 0; s < 2; s++) begin
      randomize_inputs();
      start_sprite();
      wait_idle();
    end
    rdy_rand = 0;
    pix_ready = 1'b1;

    // Abort after beat 37 with start asserted in the same cycle.
    randomize_inputs();
    hs_count = 0;
    start_sprite();
    for (int c = 0; c < 500 && hs_count < 38; c++) begin
      @(posedge clk); #1;
    end
    check("abort_reach", 32'(hs_count), 32'd38);
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    start = 1'b0;
    exp_q.delete();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(pix_valid), 32'd0);
    check("abort_last", 32'(pix_last), 32'd0);
    @(posedge clk); #1;
    check("abort_idle", 32'(busy), 32'd0);
    randomize_inputs();
    start_sprite();
    wait_idle();

    // Asynchronous reset mid-stream, then a clean restart.
    randomize_inputs();
    start_sprite();
    repeat (20) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(pix_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    randomize_inputs();
    start_sprite();
    wait_idle();

`ifdef SPRITE_SKIP_TRANSPARENT_EN
    mode = 1'b0;
    fg_color = 12'h0A5;
    mask_in = '0;
    mask_in[5] = 1'b1;
    mask_in[200] = 1'b1;
    hs_count = 0;
    start_sprite();
    wait_idle();
    check("skip_beats", 32'(hs_count), 32'd2);

    mask_in = '0;
    hs_count = 0;
    start_sprite();
    repeat (256) @(posedge clk);
    #1 force_done = 1;
    @(posedge clk); #1 force_done = 0;
    wait_idle();
    check("zero_mask_beats", 32'(hs_count), 32'd0);
`endif

    check("final_queue", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
